// File: rtl/fpll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpll_reconfig_pkg
// Description : Shared state encoding, status codes and default widths for
//               the fPLL reconfiguration master.
// Revision    : 1.0 - initial release
// ============================================================================
package fpll_reconfig_pkg;

  localparam int c_DEF_ADDR_W       = 9;
  localparam int c_DEF_DATA_W       = 8;
  localparam int c_DEF_READ_LATENCY = 2;
  localparam int c_DEF_LOCK_STABLE  = 16;
  localparam int c_DEF_LOCK_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_WR        = 3'd3,
    S_LOCK_WAIT = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_LOCK_TO = 2'b01;

endpackage
`default_nettype wire

// File: rtl/fpll_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : fpll_lock_monitor
// Description : Lock synchronizer with stable-run and saturating timeout
//               counters, active only while started.
// Revision    : 1.0 - initial release
// ============================================================================
module fpll_lock_monitor #(
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_lock,
  output logic o_done,
  output logic o_timeout
);

  localparam int c_RUN_W = $clog2(LOCK_STABLE + 1);
  localparam int c_CYC_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(LOCK_STABLE - 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(LOCK_STABLE);
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CYC_W-1:0] c_CYC_MAX  = c_CYC_W'(LOCK_TIMEOUT);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_RUN_W-1:0] r_run;
  logic [c_CYC_W-1:0] r_cyc;

  // Synchronizer is flushed on clear so every wait pays the full 2-cycle delay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_run   <= '0;
      r_cyc   <= '0;
    end else if (i_clear) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_run   <= '0;
      r_cyc   <= '0;
    end else if (i_start) begin
      r_sync1 <= i_lock;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_run <= '0;
      end else if (r_run != c_RUN_MAX) begin
        r_run <= r_run + 1'b1;
      end
      if (r_cyc != c_CYC_MAX) begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

  // Both flags describe the current cycle, letting the FSM leave on the edge
  // that completes the run or the timeout window.
  assign o_done    = r_sync2 && (r_run >= c_RUN_LAST);
  assign o_timeout = (r_cyc >= c_CYC_LAST);

endmodule
`default_nettype wire

// File: rtl/fpll_reconfig_master.sv
`default_nettype none
// ============================================================================
// Module      : fpll_reconfig_master
// Description : Byte-wide read-modify-write initiator for the fPLL Avalon-MM
//               reconfiguration port, with optional lock wait.
// Revision    : 1.0 - initial release
// ============================================================================
module fpll_reconfig_master
  import fpll_reconfig_pkg::*;
#(
  parameter int ADDR_W       = c_DEF_ADDR_W,
  parameter int DATA_W       = c_DEF_DATA_W,
  parameter int READ_LATENCY = c_DEF_READ_LATENCY,
  parameter int LOCK_STABLE  = c_DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = c_DEF_LOCK_TIMEOUT
) (
  input  logic              avmmclk,
  input  logic              avmmrstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_mask,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [ADDR_W-1:0] avmmaddress,
  output logic              avmmread,
  output logic              avmmwrite,
  output logic [DATA_W-1:0] avmmwritedata,
  input  logic [DATA_W-1:0] avmmreaddata,
  input  logic              lock
);

  localparam logic [3:0] c_LAT_LAST = 4'(READ_LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rd;
  logic              r_last;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_status;
  logic              r_busy;
  logic [ADDR_W-1:0] r_avmmaddress;
  logic              r_avmmread;
  logic              r_avmmwrite;
  logic [DATA_W-1:0] r_avmmwritedata;
  logic              w_in_lock;
  logic              w_lock_done;
  logic              w_lock_to;

  assign w_in_lock = (r_state == S_LOCK_WAIT);

  fpll_lock_monitor #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock_monitor (
    .i_clk     (avmmclk),
    .i_rst_n   (avmmrstn),
    .i_start   (w_in_lock),
    .i_clear   (!w_in_lock),
    .i_lock    (lock),
    .o_done    (w_lock_done),
    .o_timeout (w_lock_to)
  );

  always_ff @(posedge avmmclk or negedge avmmrstn) begin
    if (!avmmrstn) begin
      r_state         <= S_IDLE;
      r_lat_cnt       <= '0;
      r_mask          <= '0;
      r_data          <= '0;
      r_rd            <= '0;
      r_last          <= 1'b0;
      r_cmd_ready     <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_status    <= ST_OK;
      r_busy          <= 1'b0;
      r_avmmaddress   <= '0;
      r_avmmread      <= 1'b0;
      r_avmmwrite     <= 1'b0;
      r_avmmwritedata <= '0;
    end else begin
      r_avmmread  <= 1'b0;
      r_avmmwrite <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_mask          <= cmd_mask;
            r_data          <= cmd_data;
            r_last          <= cmd_last;
            r_rd            <= '0;
            r_avmmaddress   <= cmd_addr;
            r_avmmwritedata <= cmd_data;
            r_cmd_ready     <= 1'b0;
            r_busy          <= 1'b1;
            if (&cmd_mask) begin
              r_state     <= S_WR;
              r_avmmwrite <= 1'b1;
            end else begin
              r_state    <= S_RD;
              r_avmmread <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state   <= S_RD_WAIT;
          r_lat_cnt <= '0;
        end
        S_RD_WAIT: begin
          if (r_lat_cnt == c_LAT_LAST) begin
            r_rd <= avmmreaddata;
            if (r_mask == '0) begin
              if (r_last) begin
                r_state <= S_LOCK_WAIT;
              end else begin
                r_state      <= S_RESP;
                r_rsp_valid  <= 1'b1;
                r_rsp_rdata  <= avmmreaddata;
                r_rsp_status <= ST_OK;
              end
            end else begin
              r_state         <= S_WR;
              r_avmmwrite     <= 1'b1;
              r_avmmwritedata <= (avmmreaddata & ~r_mask) | (r_data & r_mask);
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        S_WR: begin
          if (r_last) begin
            r_state <= S_LOCK_WAIT;
          end else begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= r_rd;
            r_rsp_status <= ST_OK;
          end
        end
        S_LOCK_WAIT: begin
          // A run completing on the timeout cycle still reports success.
          if (w_lock_done || w_lock_to) begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= r_rd;
            r_rsp_status <= w_lock_done ? ST_OK : ST_LOCK_TO;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_status    = r_rsp_status;
  assign busy          = r_busy;
  assign avmmaddress   = r_avmmaddress;
  assign avmmread      = r_avmmread;
  assign avmmwrite     = r_avmmwrite;
  assign avmmwritedata = r_avmmwritedata;

endmodule
`default_nettype wire

// File: tb/tb_fpll_reconfig_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpll_reconfig_master
// Description : Directed bench for fpll_reconfig_master with a small PLL
//               register model (read latency 2, lock timeout 100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpll_reconfig_master;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic              avmmclk = 1'b0;
  logic              avmmrstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_mask;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_last;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;
  logic              busy;
  logic [ADDR_W-1:0] avmmaddress;
  logic              avmmread;
  logic              avmmwrite;
  logic [DATA_W-1:0] avmmwritedata;
  logic [DATA_W-1:0] avmmreaddata;
  logic              lock;

  always #5 avmmclk = ~avmmclk;

  fpll_reconfig_master #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (2),
    .LOCK_STABLE  (16),
    .LOCK_TIMEOUT (100)
  ) dut (
    .avmmclk       (avmmclk),
    .avmmrstn      (avmmrstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_mask      (cmd_mask),
    .cmd_data      (cmd_data),
    .cmd_last      (cmd_last),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_status    (rsp_status),
    .busy          (busy),
    .avmmaddress   (avmmaddress),
    .avmmread      (avmmread),
    .avmmwrite     (avmmwrite),
    .avmmwritedata (avmmwritedata),
    .avmmreaddata  (avmmreaddata),
    .lock          (lock)
  );

  wire [31:0] all_outs = {cmd_ready, rsp_valid, busy, avmmread, avmmwrite,
                          avmmaddress, avmmwritedata, rsp_rdata, rsp_status};

  // PLL register model: unwritten registers return a fixed seed pattern.
  logic [DATA_W-1:0] mem [0:511];
  logic              written [0:511];
  logic [DATA_W-1:0] p1 = 8'hEE;
  logic [DATA_W-1:0] p2 = 8'hEE;

  function automatic logic [DATA_W-1:0] seed_val(input logic [ADDR_W-1:0] a);
    if (a == 9'h010) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge avmmclk) begin
    p1 <= avmmread ? (written[avmmaddress] ? mem[avmmaddress] : seed_val(avmmaddress)) : 8'hEE;
    p2 <= p1;
    if (avmmwrite) begin
      mem[avmmaddress]     <= avmmwritedata;
      written[avmmaddress] <= 1'b1;
    end
  end
  assign avmmreaddata = p2;

  int n_rd = 0, n_wr = 0, n_rsp = 0, n_both = 0;
  always @(negedge avmmclk) begin
    if (avmmread) n_rd <= n_rd + 1;
    if (avmmwrite) n_wr <= n_wr + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (avmmread && avmmwrite) n_both <= n_both + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge avmmclk);
  endtask

  // Offer one command at the current negedge; returns at the negedge of T+1.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m,
                      input logic [DATA_W-1:0] d, input logic l);
    cmd_addr  = a;
    cmd_mask  = m;
    cmd_data  = d;
    cmd_last  = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt, hs, bad, r0, w0, s0;
    for (int i = 0; i < 512; i++) written[i] = 1'b0;
    avmmrstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_mask = '0;
    cmd_data = '0; cmd_last = 1'b0; lock = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", all_outs, 32'h0);
    avmmrstn = 1'b1;
    chk("ready_at_release", cmd_ready, 0);
    tick();
    chk("ready_after_release", cmd_ready, 1);

    // Full write
    r0 = n_rd;
    send(9'h1A4, 8'hFF, 8'h5C, 1'b0);
    chk("fw_write_pulse", avmmwrite, 1);
    chk("fw_no_read", avmmread, 0);
    chk("fw_addr", avmmaddress, 9'h1A4);
    chk("fw_wdata", avmmwritedata, 8'h5C);
    chk("fw_busy", busy, 1);
    tick();
    chk("fw_rsp_valid", rsp_valid, 1);
    chk("fw_rsp_rdata", rsp_rdata, 8'h00);
    chk("fw_rsp_status", rsp_status, 2'b00);
    chk("fw_ready_in_resp", cmd_ready, 0);
    chk("fw_read_count", n_rd - r0, 0);
    tick();

    // Read-modify-write: (0xA5 & 0xF0) | (0x03 & 0x0F) = 0xA3
    send(9'h010, 8'h0F, 8'h03, 1'b0);
    chk("rmw_read_pulse", avmmread, 1);
    chk("rmw_read_addr", avmmaddress, 9'h010);
    chk("rmw_no_write_t1", avmmwrite, 0);
    tick();
    chk("rmw_read_single", avmmread, 0);
    tick();
    chk("rmw_no_write_t3", avmmwrite, 0);
    tick();
    chk("rmw_write_pulse", avmmwrite, 1);
    chk("rmw_wdata", avmmwritedata, 8'hA3);
    tick();
    chk("rmw_rsp_valid", rsp_valid, 1);
    chk("rmw_rsp_rdata", rsp_rdata, 8'hA5);
    chk("rmw_rsp_status", rsp_status, 2'b00);
    tick();

    // Pure read returns the value just written
    w0 = n_wr;
    send(9'h010, 8'h00, 8'hFF, 1'b0);
    chk("pr_read_pulse", avmmread, 1);
    repeat (2) tick();
    chk("pr_no_rsp_early", rsp_valid, 0);
    tick();
    chk("pr_rsp_valid", rsp_valid, 1);
    chk("pr_rsp_rdata", rsp_rdata, 8'hA3);
    chk("pr_write_count", n_wr - w0, 0);
    tick();

    // Lock success with a mid-run glitch
    send(9'h020, 8'hFF, 8'h11, 1'b1);
    tick();
    repeat (3) tick();
    lock = 1'b1;
    repeat (12) tick();
    chk("lk_no_rsp_before_glitch", rsp_valid, 0);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("lk_latency", cnt, 18);
    chk("lk_status", rsp_status, 2'b00);
    chk("lk_rdata", rsp_rdata, 8'h00);
    lock = 1'b0;
    tick();

    // Lock timeout: LOCK_WAIT spans T+2..T+101, response at T+102
    send(9'h021, 8'hFF, 8'h22, 1'b1);
    cnt = 1;
    while (!rsp_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("to_latency", cnt, 102);
    chk("to_status", rsp_status, 2'b01);
    tick();
    chk("to_idle_ready", cmd_ready, 1);

    // Reset during RD_WAIT
    send(9'h030, 8'h0F, 8'h0F, 1'b0);
    tick();
    chk("rst_busy_before", busy, 1);
    s0 = n_rsp;
    avmmrstn = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs, 32'h0);
    repeat (2) tick();
    avmmrstn = 1'b1;
    chk("rst_ready_at_release", cmd_ready, 0);
    tick();
    chk("rst_ready_after_release", cmd_ready, 1);
    repeat (5) tick();
    chk("rst_no_response", n_rsp - s0, 0);

    // Backpressure: valid held high, accepted only in IDLE
    cmd_addr = 9'h040; cmd_mask = 8'hFF; cmd_data = 8'h77; cmd_last = 1'b0;
    cmd_valid = 1'b1;
    hs = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) hs++;
      if (cmd_ready && (rsp_valid || busy)) bad++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_handshakes", hs, 4);
    chk("bp_ready_while_busy", bad, 0);
    repeat (3) tick();
    chk("rd_wr_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
